// File: rtl/prog_load_pkg.sv
// Shared types and constants for the instruction-memory upgrade loader.
// Optional checksum trailer support is selected with PROG_LOAD_CHECKSUM_EN.
package prog_load_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_WRITE,
`ifdef PROG_LOAD_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE,
        S_ERR
    } state_t;

    localparam int LEN_BYTES       = 2;
    localparam int BYTES_PER_WORD  = 4;
    localparam int TIMEOUT_CYC_DEF = 1000000;

    // Width of a counter that must be able to hold the value cyc.
    function automatic int to_width(input int cyc);
        return $clog2(cyc + 1);
    endfunction

    localparam int TO_W = to_width(TIMEOUT_CYC_DEF);

endpackage

// File: rtl/byte_word_asm.sv
// Assembles little-endian bytes into 32-bit words. word holds the last
// complete word until the next one finishes; word_ready flags the byte
// that completes a word.
module byte_word_asm
    import prog_load_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        clr,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic        word_ready,
    output logic [31:0] word
);

    localparam int IDX_W = $clog2(BYTES_PER_WORD);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BYTES_PER_WORD - 1);

    logic [IDX_W-1:0] byte_idx;
    logic [23:0]      shift_r;

    assign word_ready = in_valid && (byte_idx == IDX_LAST);

    // Shift earlier bytes down so the first byte lands in the low lane.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            byte_idx <= '0;
            shift_r  <= '0;
            word     <= '0;
        end else if (clr) begin
            byte_idx <= '0;
            shift_r  <= '0;
        end else if (in_valid) begin
            if (word_ready) begin
                word     <= {in_byte, shift_r};
                byte_idx <= '0;
            end else begin
                shift_r  <= {in_byte, shift_r[23:8]};
                byte_idx <= byte_idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/prog_load_ctrl.sv
// Upgrade-port sequencer: UART byte frame -> instruction ROM word writes.
// Frame: LEN_LO, LEN_HI, LEN*4 data bytes (+ XOR trailer byte when
// PROG_LOAD_CHECKSUM_EN is defined).
//
// state   | meaning
// IDLE    | CPU owns memory, waiting for start_i
// LEN_LO  | waiting for word-count low byte
// LEN_HI  | waiting for word-count high byte, then range check
// DATA    | collecting bytes of the current word
// WRITE   | one-cycle memory write of the assembled word
// CHK     | waiting for checksum trailer (feature build only)
// DONE    | load succeeded, hand memory back
// ERR     | load aborted (bad length, timeout or checksum)
module prog_load_ctrl
    import prog_load_pkg::*;
#(
    parameter int ADDR_W      = 14,
    parameter int MAX_WORDS   = 16384,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start_i,
    input  logic              rx_valid_i,
    input  logic [7:0]        rx_data_i,
    output logic              upg_rst_o,
    output logic              upg_wen_o,
    output logic [ADDR_W-1:0] upg_adr_o,
    output logic [31:0]       upg_dat_o,
    output logic              upg_done_o,
    output logic              busy_o,
    output logic              err_o
);

    localparam int TW = to_width(TIMEOUT_CYC);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [16:0]   MAX_LEN = 17'(MAX_WORDS);

    state_t state, state_nxt;

    logic [15:0]       len_r;
    logic [15:0]       word_idx;
    logic [TW-1:0]     to_cnt;
    logic [ADDR_W-1:0] adr_r;
    logic              rst_r, done_r, err_r;

    logic        asm_valid, asm_clr, word_ready;
    logic [31:0] word;
    logic [15:0] len_full;
    logic        len_bad, last_word, to_active, timed_out;

`ifdef PROG_LOAD_CHECKSUM_EN
    logic [7:0] sum_r;
    logic       sum_ok;
    assign sum_ok    = (rx_data_i == sum_r);
    assign to_active = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                       (state == S_DATA)   || (state == S_CHK);
`else
    assign to_active = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                       (state == S_DATA);
`endif

    assign len_full  = {rx_data_i, len_r[7:0]};
    assign len_bad   = (len_full == 16'd0) || ({1'b0, len_full} > MAX_LEN);
    assign last_word = ((word_idx + 16'd1) == len_r);
    assign timed_out = to_active && !rx_valid_i && (to_cnt == TO_LAST);
    // A byte landing during a non-final WRITE is the next word's byte 0.
    assign asm_valid = rx_valid_i &&
                       ((state == S_DATA) || ((state == S_WRITE) && !last_word));
    assign asm_clr   = (state == S_IDLE) && start_i;

    byte_word_asm u_asm (
        .clk        (clk),
        .rstn       (rstn),
        .clr        (asm_clr),
        .in_valid   (asm_valid),
        .in_byte    (rx_data_i),
        .word_ready (word_ready),
        .word       (word)
    );

    assign upg_wen_o  = (state == S_WRITE);
    assign upg_adr_o  = adr_r;
    assign upg_dat_o  = word;
    assign upg_rst_o  = rst_r;
    assign upg_done_o = done_r;
    assign err_o      = err_r;
    assign busy_o     = (state != S_IDLE);

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode; a timeout overrides any other transition.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start_i)    state_nxt = S_LEN_LO;
            S_LEN_LO: if (rx_valid_i) state_nxt = S_LEN_HI;
            S_LEN_HI: if (rx_valid_i) state_nxt = len_bad ? S_ERR : S_DATA;
            S_DATA:   if (word_ready) state_nxt = S_WRITE;
            S_WRITE: begin
                if (last_word) begin
`ifdef PROG_LOAD_CHECKSUM_EN
                    // A trailer arriving during the final write is checked at once.
                    if (rx_valid_i) state_nxt = sum_ok ? S_DONE : S_ERR;
                    else            state_nxt = S_CHK;
`else
                    state_nxt = S_DONE;
`endif
                end else begin
                    state_nxt = S_DATA;
                end
            end
`ifdef PROG_LOAD_CHECKSUM_EN
            S_CHK:    if (rx_valid_i) state_nxt = sum_ok ? S_DONE : S_ERR;
`endif
            S_DONE:   state_nxt = S_IDLE;
            S_ERR:    state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
        if (timed_out) state_nxt = S_ERR;
    end

    // Length, word counter, address, timeout and status flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            len_r    <= '0;
            word_idx <= '0;
            to_cnt   <= '0;
            adr_r    <= '0;
            rst_r    <= 1'b1;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        rst_r    <= 1'b0;
                        done_r   <= 1'b0;
                        err_r    <= 1'b0;
                        word_idx <= '0;
                        len_r    <= '0;
                    end
                end
                S_LEN_LO: if (rx_valid_i) len_r[7:0]  <= rx_data_i;
                S_LEN_HI: if (rx_valid_i) len_r[15:8] <= rx_data_i;
                S_WRITE:  word_idx <= word_idx + 16'd1;
                S_DONE: begin
                    done_r <= 1'b1;
                    rst_r  <= 1'b1;
                end
                S_ERR: begin
                    err_r  <= 1'b1;
                    rst_r  <= 1'b1;
                    done_r <= 1'b0;
                end
                default: ;
            endcase
            if ((state == S_DATA) && word_ready) adr_r <= word_idx[ADDR_W-1:0];
            if (to_active && !rx_valid_i) to_cnt <= to_cnt + TW'(1);
            else                          to_cnt <= '0;
        end
    end

`ifdef PROG_LOAD_CHECKSUM_EN
    // Running XOR of every data byte in the current load.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)          sum_r <= '0;
        else if (asm_clr)   sum_r <= '0;
        else if (asm_valid) sum_r <= sum_r ^ rx_data_i;
    end
`endif

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Bench for prog_load_ctrl; adds trailer bytes and the checksum scenario
// when PROG_LOAD_CHECKSUM_EN is defined.
module tb_prog_load_ctrl;

    localparam int ADDR_W = 14;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              start_i = 1'b0;
    logic              rx_valid_i = 1'b0;
    logic [7:0]        rx_data_i = 8'h00;
    logic              upg_rst_o, upg_wen_o, upg_done_o, busy_o, err_o;
    logic [ADDR_W-1:0] upg_adr_o;
    logic [31:0]       upg_dat_o;

    int total = 0;
    int bad   = 0;

    logic [ADDR_W+31:0] exp_q[$];
    logic [ADDR_W+31:0] got_q[$];
    logic [7:0]         data_q[$];

    prog_load_ctrl #(.ADDR_W(ADDR_W), .MAX_WORDS(64), .TIMEOUT_CYC(16)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start_i    (start_i),
        .rx_valid_i (rx_valid_i),
        .rx_data_i  (rx_data_i),
        .upg_rst_o  (upg_rst_o),
        .upg_wen_o  (upg_wen_o),
        .upg_adr_o  (upg_adr_o),
        .upg_dat_o  (upg_dat_o),
        .upg_done_o (upg_done_o),
        .busy_o     (busy_o),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    // Capture every memory write seen on the port.
    always @(negedge clk) begin
        if (upg_wen_o === 1'b1) got_q.push_back({upg_adr_o, upg_dat_o});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    // Sends len + data_q (+ trailer), pushing expected writes as it goes.
    task automatic send_frame(input bit b2b, input bit bad_sum, input int start_at);
        logic [7:0]        bytes[$];
        logic [7:0]        x;
        logic [ADDR_W-1:0] a;
        int                n;
        n = data_q.size() / 4;
        x = 8'h00;
        bytes.push_back(n[7:0]);
        bytes.push_back(n[15:8]);
        foreach (data_q[i]) begin
            bytes.push_back(data_q[i]);
            x = x ^ data_q[i];
        end
        for (int w = 0; w < n; w++) begin
            a = ADDR_W'(w);
            exp_q.push_back({a, data_q[4*w+3], data_q[4*w+2], data_q[4*w+1], data_q[4*w]});
        end
`ifdef PROG_LOAD_CHECKSUM_EN
        bytes.push_back(x ^ {7'd0, bad_sum});
`endif
        foreach (bytes[i]) begin
            rx_valid_i = 1'b1;
            rx_data_i  = bytes[i];
            start_i    = (i == start_at);
            tick();
            start_i = 1'b0;
            if (!b2b) begin
                rx_valid_i = 1'b0;
                tick();
            end
        end
        rx_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int cyc;
        cyc = 0;
        while (busy_o === 1'b1 && cyc < 60) begin
            tick();
            cyc++;
        end
        total++;
        if (busy_o !== 1'b0) begin
            bad++;
            $display("FAIL %s idle_wait: busy=%b after %0d cycles, need 0", name, busy_o, cyc);
        end
    endtask

    task automatic compare_writes(input string name);
        logic [ADDR_W+31:0] e, g;
        total++;
        if (got_q.size() !== exp_q.size()) begin
            bad++;
            $display("FAIL %s write_count: got %0d need %0d", name, got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL %s write: got adr=%0d dat=%h need adr=%0d dat=%h",
                         name, g[ADDR_W+31:32], g[31:0], e[ADDR_W+31:32], e[31:0]);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_reset();
        repeat (2) tick();
        total++;
        if ({upg_rst_o, upg_wen_o, upg_done_o, busy_o, err_o} !== 5'b10000) begin
            bad++;
            $display("FAIL reset flags: got rst,wen,done,busy,err=%b need 10000",
                     {upg_rst_o, upg_wen_o, upg_done_o, busy_o, err_o});
        end
        total++;
        if (upg_adr_o !== '0 || upg_dat_o !== 32'h0) begin
            bad++;
            $display("FAIL reset adr_dat: got %0d/%h need 0/00000000", upg_adr_o, upg_dat_o);
        end
        rstn = 1'b1;
        tick();
        total++;
        if (upg_rst_o !== 1'b1 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL reset release: got rst=%b busy=%b need 1/0", upg_rst_o, busy_o);
        end
    endtask

    task automatic test_normal();
        data_q = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h78, 8'h56, 8'h34, 8'h12};
        pulse_start();
        total++;
        if (upg_rst_o !== 1'b0 || busy_o !== 1'b1) begin
            bad++;
            $display("FAIL normal start: got rst=%b busy=%b need 0/1", upg_rst_o, busy_o);
        end
        send_frame(1'b0, 1'b0, -1);
        wait_idle("normal");
        compare_writes("normal");
        total++;
        if ({upg_done_o, upg_rst_o, err_o, upg_wen_o} !== 4'b1100) begin
            bad++;
            $display("FAIL normal status: got done,rst,err,wen=%b need 1100",
                     {upg_done_o, upg_rst_o, err_o, upg_wen_o});
        end
        total++;
        if (upg_dat_o !== 32'h12345678 || upg_adr_o !== 14'd1) begin
            bad++;
            $display("FAIL normal hold: got adr=%0d dat=%h need 1/12345678", upg_adr_o, upg_dat_o);
        end
    endtask

    task automatic test_back_to_back();
        data_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hA5, 8'h5A, 8'hC3, 8'h3C,
                   8'hFF, 8'h00, 8'h81, 8'h7E};
        pulse_start();
        send_frame(1'b1, 1'b0, -1);
        wait_idle("b2b");
        compare_writes("b2b");
        total++;
        if (upg_done_o !== 1'b1 || err_o !== 1'b0) begin
            bad++;
            $display("FAIL b2b status: got done=%b err=%b need 1/0", upg_done_o, err_o);
        end
    endtask

    task automatic test_bad_len();
        pulse_start();
        rx_valid_i = 1'b1;
        rx_data_i  = 8'h00;
        tick();
        tick();
        rx_valid_i = 1'b0;
        tick();
        total++;
        if (err_o !== 1'b1 || upg_rst_o !== 1'b1 || upg_done_o !== 1'b0) begin
            bad++;
            $display("FAIL badlen zero: got err=%b rst=%b done=%b need 1/1/0",
                     err_o, upg_rst_o, upg_done_o);
        end
        compare_writes("badlen_zero");
        pulse_start();
        total++;
        if (err_o !== 1'b0) begin
            bad++;
            $display("FAIL badlen restart: got err=%b need 0", err_o);
        end
        rx_valid_i = 1'b1;
        rx_data_i  = 8'h41;
        tick();
        rx_data_i  = 8'h00;
        tick();
        rx_data_i  = 8'h01;
        tick();
        rx_valid_i = 1'b0;
        total++;
        if (err_o !== 1'b1 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL badlen over: got err=%b busy=%b need 1/0", err_o, busy_o);
        end
        compare_writes("badlen_over");
    endtask

    task automatic test_timeout();
        int cyc;
        pulse_start();
        rx_valid_i = 1'b1;
        rx_data_i  = 8'h01;
        tick();
        rx_data_i  = 8'h00;
        tick();
        rx_data_i  = 8'hAA;
        tick();
        rx_valid_i = 1'b0;
        cyc = 0;
        while (err_o !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        total++;
        if (cyc < 16 || cyc > 18) begin
            bad++;
            $display("FAIL timeout delay: got %0d cycles need 16..18", cyc);
        end
        total++;
        if (busy_o !== 1'b0 || upg_rst_o !== 1'b1) begin
            bad++;
            $display("FAIL timeout state: got busy=%b rst=%b need 0/1", busy_o, upg_rst_o);
        end
        compare_writes("timeout");
        data_q = '{8'h10, 8'h20, 8'h30, 8'h40};
        pulse_start();
        total++;
        if (err_o !== 1'b0) begin
            bad++;
            $display("FAIL timeout clear: got err=%b need 0", err_o);
        end
        send_frame(1'b0, 1'b0, -1);
        wait_idle("timeout_retry");
        compare_writes("timeout_retry");
        total++;
        if (upg_done_o !== 1'b1 || err_o !== 1'b0) begin
            bad++;
            $display("FAIL timeout retry: got done=%b err=%b need 1/0", upg_done_o, err_o);
        end
    endtask

    task automatic test_start_and_reset();
        data_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        pulse_start();
        send_frame(1'b0, 1'b0, 4);
        wait_idle("start_ignored");
        compare_writes("start_ignored");
        total++;
        if (upg_done_o !== 1'b1 || err_o !== 1'b0) begin
            bad++;
            $display("FAIL start_ignored status: got done=%b err=%b need 1/0", upg_done_o, err_o);
        end
        pulse_start();
        rx_valid_i = 1'b1;
        rx_data_i  = 8'h01;
        tick();
        rx_data_i  = 8'h00;
        tick();
        rx_data_i  = 8'hAA;
        tick();
        rx_valid_i = 1'b0;
        rstn = 1'b0;
        #2;
        total++;
        if ({upg_rst_o, upg_wen_o, upg_done_o, busy_o, err_o} !== 5'b10000) begin
            bad++;
            $display("FAIL midreset flags: got rst,wen,done,busy,err=%b need 10000",
                     {upg_rst_o, upg_wen_o, upg_done_o, busy_o, err_o});
        end
        total++;
        if (upg_adr_o !== '0 || upg_dat_o !== 32'h0) begin
            bad++;
            $display("FAIL midreset adr_dat: got %0d/%h need 0/00000000", upg_adr_o, upg_dat_o);
        end
        rstn = 1'b1;
        tick();
        compare_writes("midreset");
    endtask

`ifdef PROG_LOAD_CHECKSUM_EN
    task automatic test_checksum();
        data_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        pulse_start();
        send_frame(1'b0, 1'b0, -1);
        wait_idle("chk_good");
        compare_writes("chk_good");
        total++;
        if (upg_done_o !== 1'b1 || err_o !== 1'b0) begin
            bad++;
            $display("FAIL chk_good status: got done=%b err=%b need 1/0", upg_done_o, err_o);
        end
        pulse_start();
        send_frame(1'b0, 1'b1, -1);
        wait_idle("chk_bad");
        compare_writes("chk_bad");
        total++;
        if (upg_done_o !== 1'b0 || err_o !== 1'b1) begin
            bad++;
            $display("FAIL chk_bad status: got done=%b err=%b need 0/1", upg_done_o, err_o);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_normal();
        test_back_to_back();
        test_bad_len();
        test_timeout();
        test_start_and_reset();
`ifdef PROG_LOAD_CHECKSUM_EN
        test_checksum();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prog_load_ctrl.md
Name: prog_load_ctrl

Overview:
- Sequencer for the instruction-memory upgrade port. It turns a UART byte stream into word writes on the instruction ROM (`upg_wen_o`, `upg_adr_o`, `upg_dat_o`) and signals completion through `upg_rst_o` / `upg_done_o`.
- Sits between the UART receiver and the instruction-fetch stage.
- Fetch-side mux mode is `upg_rst | (~upg_rst & upg_done)`. Low means the memory port is owned by this block.

Parameters:
- ADDR_W, 14, word-address width of the instruction memory.
- MAX_WORDS, 16384, largest legal word count in the header.
- TIMEOUT_CYC, 1000000, idle cycles between bytes before a load aborts (16 in simulation).

Ports:
- clk  in  1  upgrade clock; the block and the memory write port share it.
- rstn  in  1  reset, asynchronous, active-low.
- start_i  in  1  one-cycle request to begin a load.
- rx_valid_i  in  1  one-cycle strobe: rx_data_i holds a received byte.
- rx_data_i  in  8  received byte.
- upg_rst_o  out  1  1 = CPU owns the memory; 0 = a load is in progress.
- upg_wen_o  out  1  memory write enable, one-cycle pulse per word.
- upg_adr_o  out  ADDR_W  memory word address.
- upg_dat_o  out  32  memory write data.
- upg_done_o  out  1  sticky: last load completed successfully.
- busy_o  out  1  state is not IDLE.
- err_o  out  1  sticky: last load aborted.

Behaviour:
- Reset values: upg_rst_o=1. All other outputs 0. State IDLE, all counters 0.
- Frame format, all little-endian: LEN_LO, LEN_HI (16-bit word count), then LEN×4 data bytes.
- States: IDLE, LEN_LO, LEN_HI, DATA, WRITE, CHK (feature only), DONE, ERR.
- IDLE:
  - start_i → LEN_LO, with upg_rst_o=0, upg_done_o=0, err_o=0, byte_idx=0, word_idx=0, timeout counter=0.
  - rx_valid_i in IDLE is ignored.
- start_i while busy_o=1 is ignored.
- LEN_LO / LEN_HI: each accepted byte latches the matching half of len.
- On LEN_HI accept, check len:
  - len==0 or len>MAX_WORDS → ERR.
  - Otherwise → DATA.
- DATA:
  - Byte b goes to assembly word bits [8*byte_idx +: 8]; byte_idx increments.
  - The 4th byte (byte_idx==3) moves to WRITE.
- WRITE (exactly one cycle):
  - upg_wen_o=1, upg_adr_o=word_idx[ADDR_W-1:0], upg_dat_o=assembled word.
  - word_idx increments and byte_idx returns to 0.
  - Next state is DONE if word_idx+1==len, otherwise DATA.
  - A byte arriving during WRITE is accepted into the assembly word as byte 0. Its byte is not lost.
- Latency: upg_wen_o rises the cycle after the 4th byte's rx_valid_i.
- upg_adr_o and upg_dat_o hold their last values between writes. upg_wen_o is 0 outside WRITE.
- DONE (one cycle): upg_done_o=1, upg_rst_o=1, then → IDLE.
- ERR (one cycle): err_o=1, upg_rst_o=1, upg_done_o=0, then → IDLE.
  - Memory already written is left as-is.
- Timeout, active in LEN_LO, LEN_HI, DATA and CHK:
  - The counter clears on every accepted byte and increments otherwise.
  - Reaching TIMEOUT_CYC → ERR.
- Bytes received beyond the frame, after DONE, are ignored.
- rstn asserted mid-load:
  - Immediate return to reset values; the load is abandoned.
  - Memory contents are undefined for the partial range.

Optional Feature:
- Macro: PROG_LOAD_CHECKSUM_EN.
- Defined:
  - After the last WRITE, go to CHK and wait for one trailer byte.
  - If it equals the XOR of all data bytes → DONE, otherwise → ERR.
  - Timeout applies in CHK.
  - The running XOR clears on start.
- Undefined:
  - No CHK state and no trailer byte.
  - The last WRITE goes directly to DONE.

Decomposition:
- Package prog_load_pkg holds:
  - the state enum;
  - LEN_BYTES=2 and BYTES_PER_WORD=4;
  - the width localparam for the timeout counter, $clog2(TIMEOUT_CYC+1).
- Sub-module byte_word_asm: byte shift-in, byte_idx counter, word_ready pulse.
- The FSM, counters and timeout stay in prog_load_ctrl.

Test Plan:
- Normal load:
  - Stimulus: start; bytes 02 00 EF BE AD DE 78 56 34 12.
  - Response: wen at adr 0 with DEADBEEF, then adr 1 with 12345678; then upg_done_o=1, upg_rst_o=1, err_o=0.
- Back-to-back bytes: rx_valid_i high every cycle for a 3-word frame → 3 single-cycle wen pulses at adr 0, 1, 2, no dropped byte, data matches.
- Bad length: start; 00 00 → err_o=1 and upg_rst_o=1 two cycles after LEN_HI; no wen. Then send 41 00 01 with MAX_WORDS=64 → err_o=1.
- Timeout (TIMEOUT_CYC=16):
  - Stimulus: start; 01 00 AA, then silence.
  - Response: err_o=1 after 16 idle cycles, no wen, busy_o=0.
  - Then a second start with a full 1-word frame → err_o cleared, done=1.
- Reset and ignored start:
  - Pulse start mid-DATA → no effect.
  - Assert rstn=0 mid-DATA → all outputs return to reset values within the same cycle.
- Checksum (PROG_LOAD_CHECKSUM_EN):
  - Frame 01 00 11 22 33 44 trailer 44 → done=1.
  - Same frame with trailer 45 → err_o=1 and done=0, with wen still having occurred at adr 0.
